// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam int WD_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arb2
// Description : Combinational 2-way round-robin grant selection.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arb2
  import apb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = M_CPU;
    // On a tie the master that did not own the bus last time wins.
    if (&i_req) begin
      o_grant_idx = ~i_last;
    end else if (i_req[M_DBG]) begin
      o_grant_idx = M_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_arbiter
// Description : Two-master APB arbiter with round-robin grant, APB phase
//               sequencing and an ACCESS-phase watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH/8-1:0] m0_stb,
  output logic                    m0_done,
  output logic                    m0_err,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH/8-1:0] m1_stb,
  output logic                    m1_done,
  output logic                    m1_err,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    pready,
  input  logic                    perr,
  output logic                    apb_timeout,
  output logic                    grant,
  output logic                    busy
);

  localparam int SW = DATA_WIDTH / 8;

  apb_state_e              r_state;
  apb_state_e              w_state_nxt;
  logic                    r_grant;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pdata;
  logic                    r_pwrite;
  logic [SW-1:0]           r_pstb;
  logic [WD_WIDTH-1:0]     r_wd;
  logic [1:0]              r_done;
  logic [1:0]              r_err;
  logic [DATA_WIDTH-1:0]   r_rdata0;
  logic [DATA_WIDTH-1:0]   r_rdata1;
  logic                    r_timeout;

  logic [1:0]              w_eligible;
  logic                    w_gnt_valid;
  logic                    w_gnt_idx;
  logic                    w_complete;
  logic                    w_expired;

  // A master whose done pulse is still visible is not re-granted this cycle.
  assign w_eligible = {m1_req & ~r_done[1], m0_req & ~r_done[0]};
  assign w_expired  = (r_wd == WD_WIDTH'(TIMEOUT));

  apb_rr_arb2 u_rr (
    .i_req         (w_eligible),
    .i_last        (r_grant),
    .o_grant_valid (w_gnt_valid),
    .o_grant_idx   (w_gnt_idx)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) w_state_nxt = SETUP;
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        if (pready || w_expired) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_grant   <= M_DBG;
      r_paddr   <= '0;
      r_pdata   <= '0;
      r_pwrite  <= 1'b0;
      r_pstb    <= '0;
      r_wd      <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;

      if (r_state == IDLE && w_gnt_valid) begin
        r_grant  <= w_gnt_idx;
        r_paddr  <= w_gnt_idx ? m1_addr  : m0_addr;
        r_pdata  <= w_gnt_idx ? m1_wdata : m0_wdata;
        r_pwrite <= w_gnt_idx ? m1_write : m0_write;
        r_pstb   <= w_gnt_idx ? m1_stb   : m0_stb;
      end

      if (r_state == SETUP) begin
        r_wd <= WD_WIDTH'(1);
      end else if (r_state == ACCESS && !w_complete) begin
        r_wd <= r_wd + WD_WIDTH'(1);
      end else begin
        r_wd <= '0;
      end

      // pready wins over an expiring watchdog in the same cycle.
      if (w_complete) begin
        r_done[r_grant] <= 1'b1;
        r_err[r_grant]  <= pready ? perr : 1'b1;
        r_timeout       <= ~pready;
        if (pready && !r_pwrite) begin
          if (r_grant == M_DBG) r_rdata1 <= prdata;
          else                  r_rdata0 <= prdata;
        end
      end
    end
  end

  assign psel        = (r_state != IDLE);
  assign penable     = (r_state == ACCESS);
  assign busy        = (r_state != IDLE);
  assign paddr       = r_paddr;
  assign pdata       = r_pdata;
  assign pwrite      = r_pwrite;
  assign pstb        = r_pstb;
  assign grant       = r_grant;
  assign apb_timeout = r_timeout;
  assign m0_done     = r_done[0];
  assign m1_done     = r_done[1];
  assign m0_err      = r_err[0];
  assign m1_err      = r_err[1];
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_arbiter
// Description : Self-checking bench for apb_arbiter with a wait-state slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int NV = 8;

  logic          pclk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    wr;
  logic [SW-1:0] stb [2];
  logic [1:0]    done;
  logic [1:0]    err;
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic [DW-1:0] prdata = '0;
  logic          psel, penable, pwrite;
  logic [SW-1:0] pstb;
  logic          pready = 1'b0;
  logic          perr = 1'b0;
  logic          apb_timeout, grant, busy;

  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  int            acc = 0;

  int            n_chk = 0;
  int            n_pass = 0;

  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          cap_wr;
  logic [SW-1:0] cap_stb;
  int            cap_setup;

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [SW-1:0] stb;
    int            wt;
    logic [DW-1:0] prd;
    logic          perr;
    int            lat;
    int            pen;
    logic          err;
    logic [DW-1:0] rdata;
    logic          to;
  } vec_t;

  vec_t vec [NV];

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_write(wr[0]),
    .m0_stb(stb[0]), .m0_done(done[0]), .m0_err(err[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_write(wr[1]),
    .m1_stb(stb[1]), .m1_done(done[1]), .m1_err(err[1]), .m1_rdata(rdata[1]),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr),
    .apb_timeout(apb_timeout), .grant(grant), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // Slave raises pready after slv_wait ACCESS cycles have elapsed.
  always @(negedge pclk) begin
    if (psel && penable) begin
      acc    = acc + 1;
      pready = (acc > slv_wait);
    end else begin
      acc    = 0;
      pready = 1'b0;
    end
    prdata = slv_rdata;
    perr   = slv_err;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_done(output int who, output int cyc, output int pen);
    who = -1;
    cyc = 0;
    pen = 0;
    cap_setup = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      cyc++;
      if (penable) pen++;
      if (psel && !penable) begin
        cap_addr  = paddr;
        cap_data  = pdata;
        cap_wr    = pwrite;
        cap_stb   = pstb;
        cap_setup = cyc;
      end
      if (done != 2'b00) begin
        who = done[1] ? 1 : 0;
        break;
      end
    end
  endtask

  initial begin
    int who, cyc, pen, m, seen;
    vec_t v;

    vec[0] = '{0, 32'h2000_0004, 32'h3,         1'b1, 4'hF, 1,  32'h0,         1'b0, 4,  2,  1'b0, 32'h0,         1'b0};
    vec[1] = '{1, 32'h2000_0000, 32'h0,         1'b0, 4'hF, 0,  32'hDEAD_BEEF, 1'b0, 3,  1,  1'b0, 32'hDEAD_BEEF, 1'b0};
    vec[2] = '{1, 32'h2000_0008, 32'h55,        1'b1, 4'h1, 0,  32'h1234_5678, 1'b0, 3,  1,  1'b0, 32'hDEAD_BEEF, 1'b0};
    vec[3] = '{0, 32'h2000_0010, 32'h0,         1'b0, 4'hF, 0,  32'hCAFE_F00D, 1'b1, 3,  1,  1'b1, 32'hCAFE_F00D, 1'b0};
    vec[4] = '{1, 32'h2000_000C, 32'h0,         1'b0, 4'hF, 99, 32'h1111_1111, 1'b0, 18, 16, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vec[5] = '{0, 32'h2000_0014, 32'h0,         1'b0, 4'hC, 2,  32'hA5A5_A5A5, 1'b0, 5,  3,  1'b0, 32'hA5A5_A5A5, 1'b0};
    vec[6] = '{0, 32'h2000_0018, 32'h0BAD_CAFE, 1'b1, 4'h3, 15, 32'h0,         1'b0, 18, 16, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vec[7] = '{0, 32'h2000_001C, 32'h0,         1'b0, 4'hF, 16, 32'h7777_7777, 1'b0, 18, 16, 1'b1, 32'hA5A5_A5A5, 1'b1};

    rst = 1'b1;
    req = 2'b00;
    wr  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
      stb[i]   = '0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_ctl", {psel, penable, busy, done, err, apb_timeout, grant}, 9'b0_0_0_00_00_0_1);
    check("rst_rdata", {rdata[0], rdata[1]}, 64'h0);
    check("rst_bus", {paddr, pwrite, pstb}, 37'h0);
    check("rst_pdata", pdata, 32'h0);
    rst = 1'b0;
    @(negedge pclk);

    // Simultaneous requests: two rounds, m0 first each time.
    slv_wait = 0;
    addr[0] = 32'h2000_0100;
    addr[1] = 32'h2000_0200;
    wr = 2'b11;
    for (int r = 0; r < 2; r++) begin
      req = 2'b11;
      wait_done(who, cyc, pen);
      check("arb_first", who, 0);
      check("arb_first_lat", cyc, 3);
      req[0] = 1'b0;
      wait_done(who, cyc, pen);
      check("arb_second", who, 1);
      check("arb_gap", cyc, 3);
      req[1] = 1'b0;
      @(negedge pclk);
    end
    check("arb_rdata", {rdata[0], rdata[1]}, 64'h0);

    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      slv_wait  = v.wt;
      slv_rdata = v.prd;
      slv_err   = v.perr;
      m = v.m;
      addr[m]  = v.addr;
      wdata[m] = v.wdata;
      wr[m]    = v.wr;
      stb[m]   = v.stb;
      req[m]   = 1'b1;
      wait_done(who, cyc, pen);
      req[m]   = 1'b0;
      check($sformatf("v%0d_who", i), who, m);
      check($sformatf("v%0d_lat", i), cyc, v.lat);
      check($sformatf("v%0d_setup", i), cap_setup, 1);
      check($sformatf("v%0d_pen", i), pen, v.pen);
      check($sformatf("v%0d_err", i), err[m], v.err);
      check($sformatf("v%0d_rdata", i), rdata[m], v.rdata);
      check($sformatf("v%0d_timeout", i), apb_timeout, v.to);
      check($sformatf("v%0d_other", i), {done[1-m], err[1-m]}, 2'b00);
      check($sformatf("v%0d_grant", i), grant, m);
      check($sformatf("v%0d_bus", i), {cap_addr, cap_wr, cap_stb}, {v.addr, v.wr, v.stb});
      check($sformatf("v%0d_pdata", i), cap_data, v.wdata);
      @(posedge pclk);
      @(negedge pclk);
      check($sformatf("v%0d_pulse", i), {done, apb_timeout, psel}, 4'b0000);
    end

    // Reset in the middle of an ACCESS phase.
    slv_wait  = 1000;
    slv_rdata = 32'h0BAD_F00D;
    slv_err   = 1'b0;
    addr[0] = 32'h2000_0020;
    wr[0]   = 1'b0;
    req[0]  = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge pclk);
      if (penable) seen++;
    end
    check("rst_mid_access", seen, 3);
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("rst_mid_ctl", {psel, penable, busy, done, apb_timeout, grant}, 7'b000_00_0_1);
    check("rst_mid_rdata", rdata[1], 32'h0);
    rst = 1'b0;
    req[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (done != 2'b00 || psel) seen++;
    end
    check("rst_mid_quiet", seen, 0);
    slv_wait = 0;
    req[0] = 1'b1;
    wait_done(who, cyc, pen);
    req[0] = 1'b0;
    check("post_rst_who", who, 0);
    check("post_rst_lat", cyc, 3);
    check("post_rst_err", {err[0], apb_timeout}, 2'b00);
    check("post_rst_rdata", rdata[0], 32'h0BAD_F00D);
    @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
